// File: rtl/l1_mem_arbiter.sv
// Shares one physical-memory port between I-cache fills and D-cache fills/writebacks.
// D-cache wins by default; a streak counter forces an I grant after STARVE_LIMIT consecutive D grants.
module l1_mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int LINE_W       = 128,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_resp,
    output logic [LINE_W-1:0] i_rdata,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic              d_resp,
    output logic [LINE_W-1:0] d_rdata,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    logic [1:0]    state;
    logic [SW-1:0] streak;
    logic          d_req;
    logic          i_starved;
    logic          grant_d;
    logic          grant_i;

    function automatic logic [SW-1:0] streak_inc(input logic [SW-1:0] s);
        return (s == LIMIT) ? s : s + 1'b1;
    endfunction

    always_comb begin
        d_req     = d_read | d_write;
        i_starved = i_read && (streak == LIMIT) && (STARVE_LIMIT != 0);
        grant_d   = (state == IDLE) && d_req && !i_starved;
        grant_i   = (state == IDLE) && !grant_d && i_read;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            streak       <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // A combined read+write from the D-cache is a writeback.
                    if (grant_d) begin
                        state        <= SERVE_D;
                        pmem_read    <= ~d_write;
                        pmem_write   <= d_write;
                        pmem_address <= d_addr;
                        pmem_wdata   <= d_wdata;
                        streak       <= i_read ? streak_inc(streak) : '0;
                    end else if (grant_i) begin
                        state        <= SERVE_I;
                        pmem_read    <= 1'b1;
                        pmem_write   <= 1'b0;
                        pmem_address <= i_addr;
                        streak       <= '0;
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state      <= IDLE;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Responses are combinational so the requester sees data in the pmem_resp cycle.
    assign i_resp  = (state == SERVE_I) && pmem_resp;
    assign d_resp  = (state == SERVE_D) && pmem_resp;
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

endmodule
